// File: rtl/user_io_fifo_if.sv
// Event stream between the SPI decoder and the input logic: one typed byte per
// valid/ready handshake.
interface user_io_fifo_if;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [1:0] EVT_TYPE;
  logic [7:0] EVT_DATA;

  modport master (output EVT_VALID, output EVT_TYPE, output EVT_DATA, input EVT_READY);
  modport slave  (input EVT_VALID, input EVT_TYPE, input EVT_DATA, output EVT_READY);
endinterface

// File: rtl/user_io_fifo.sv
// SPI slave for the IO controller link, oversampled in CLK. Decodes command frames into
// joystick/button/status registers and queues mouse/keyboard/OSD bytes in an event FIFO.
module user_io_fifo #(
  parameter int JOY_COUNT  = 2,
  parameter int JOY_WIDTH  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           SPI_CLK,
  input  logic                           SPI_SS_IO,
  input  logic                           SPI_MOSI,
  output logic                           SPI_MISO,
  input  logic [7:0]                     CORE_TYPE,
  output logic [JOY_COUNT*JOY_WIDTH-1:0] JOY,
  output logic [1:0]                     BUTTONS,
  output logic [1:0]                     SWITCHES,
  output logic [31:0]                    STATUS,
  output logic [2:0]                     MOUSE_BUTTONS,
  user_io_fifo_if.master                 EVT,
  output logic                           EVT_OVERFLOW
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Input synchronisers; edges are taken between stages 2 and 3.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sync_reg;
  logic [1:0] ss_sync_reg;
  logic [1:0] mosi_sync_reg;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sclk_sync_reg <= 3'b000;
      ss_sync_reg   <= 2'b11;
      mosi_sync_reg <= 2'b00;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], SPI_CLK};
      ss_sync_reg   <= {ss_sync_reg[0], SPI_SS_IO};
      mosi_sync_reg <= {mosi_sync_reg[0], SPI_MOSI};
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic ss_high;
  logic mosi_bit;

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign ss_high   = ss_sync_reg[1];
  // MOSI goes through the same two stages as SPI_CLK so it lines up with the edge.
  assign mosi_bit  = mosi_sync_reg[1];

  // ---------------------------------------------------------------------------
  // Frame deserialiser
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt_reg;
  logic [2:0] byte_cnt_reg;
  logic [7:0] cmd_reg;
  logic [6:0] shift_reg;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       is_cmd_byte;
  logic       payload_done;

  assign rx_byte      = {shift_reg, mosi_bit};
  assign is_cmd_byte  = (byte_cnt_reg == 3'd0);
  assign byte_done    = sclk_rise & ~ss_high & (bit_cnt_reg == 3'd7);
  assign payload_done = byte_done & ~is_cmd_byte;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 3'd0;
      cmd_reg      <= 8'h00;
      shift_reg    <= 7'd0;
    end else if (ss_high) begin
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 3'd0;
      cmd_reg      <= 8'h00;
      shift_reg    <= 7'd0;
    end else if (sclk_rise) begin
      shift_reg   <= rx_byte[6:0];
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
      if (bit_cnt_reg == 3'd7) begin
        if (byte_cnt_reg != 3'd7) begin
          byte_cnt_reg <= byte_cnt_reg + 3'd1;
        end
        if (is_cmd_byte) begin
          cmd_reg <= rx_byte;
        end
      end
    end
  end

  // CORE_TYPE bit 7 is pre-loaded while deselected so it is valid before the first rise.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      SPI_MISO <= 1'b0;
    end else if (ss_high) begin
      SPI_MISO <= CORE_TYPE[7];
    end else if (sclk_fall) begin
      SPI_MISO <= is_cmd_byte ? CORE_TYPE[3'd7 - bit_cnt_reg] : 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register commands
  // ---------------------------------------------------------------------------
  logic [3:0]  but_sw_reg;
  logic [2:0]  mouse_btn_reg;
  logic [23:0] shadow_reg;
  logic [31:0] status_reg;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      but_sw_reg    <= 4'd0;
      mouse_btn_reg <= 3'd0;
      shadow_reg    <= 24'd0;
      status_reg    <= 32'd0;
    end else if (ss_high) begin
      shadow_reg <= 24'd0;
    end else if (payload_done) begin
      case (cmd_reg)
        8'h01: if (byte_cnt_reg == 3'd1) but_sw_reg <= rx_byte[3:0];
        8'h04: if (byte_cnt_reg == 3'd3) mouse_btn_reg <= rx_byte[2:0];
        8'h1E: begin
          // Only the fourth byte commits, so an aborted write never tears STATUS.
          case (byte_cnt_reg)
            3'd1:    shadow_reg[7:0]   <= rx_byte;
            3'd2:    shadow_reg[15:8]  <= rx_byte;
            3'd3:    shadow_reg[23:16] <= rx_byte;
            3'd4:    status_reg        <= {rx_byte, shadow_reg};
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign BUTTONS       = but_sw_reg[1:0];
  assign SWITCHES      = but_sw_reg[3:2];
  assign STATUS        = status_reg;
  assign MOUSE_BUTTONS = mouse_btn_reg;

  genvar gi;
  generate
    for (gi = 0; gi < JOY_COUNT; gi++) begin : g_joy
      // Joysticks 0/1 use commands 0x02/0x03, joysticks 2/3 use 0x10/0x11.
      localparam int          CMD_I   = (gi < 2) ? (2 + gi) : (16 + gi - 2);
      localparam logic [7:0]  JOY_CMD = CMD_I[7:0];
      logic [JOY_WIDTH-1:0] joy_reg;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          joy_reg <= '0;
        end else if (payload_done && byte_cnt_reg == 3'd1 && cmd_reg == JOY_CMD) begin
          joy_reg <= rx_byte[JOY_WIDTH-1:0];
        end
      end

      assign JOY[gi*JOY_WIDTH +: JOY_WIDTH] = joy_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic       push_req;
  logic [9:0] push_word;

  always_comb begin
    push_req  = 1'b0;
    push_word = 10'd0;
    if (payload_done) begin
      case (cmd_reg)
        8'h04: begin
          if (byte_cnt_reg == 3'd1) begin
            push_req  = 1'b1;
            push_word = {2'd0, rx_byte};
          end else if (byte_cnt_reg == 3'd2) begin
            push_req  = 1'b1;
            push_word = {2'd1, rx_byte};
          end
        end
        8'h05: begin
          push_req  = 1'b1;
          push_word = {2'd2, rx_byte};
        end
        8'h06: begin
          push_req  = 1'b1;
          push_word = {2'd3, rx_byte};
        end
        default: ;
      endcase
    end
  end

  logic [9:0]       mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             fifo_valid;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             clear_ovf;

  assign fifo_valid = (count_reg != '0);
  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign pop        = fifo_valid & EVT.EVT_READY;
  // A push into a full FIFO only fits if the head leaves in the same cycle.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign clear_ovf  = byte_done & is_cmd_byte & (rx_byte == 8'h07);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= 10'd0;
      end
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= push_word;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
      if (push_req && !push_ok) begin
        overflow_reg <= 1'b1;
      end else if (clear_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign EVT.EVT_VALID = fifo_valid;
  assign EVT.EVT_TYPE  = mem_reg[rd_ptr_reg][9:8];
  assign EVT.EVT_DATA  = mem_reg[rd_ptr_reg][7:0];
  assign EVT_OVERFLOW  = overflow_reg;

endmodule
